// File: rtl/spawn_slot_scheduler.sv
// rtl/spawn_slot_scheduler.sv - paces pooled-object spawns into free slots, round-robin
module spawn_slot_scheduler #(
    parameter int NUM_SLOTS     = 16,
    parameter int PEND_W        = 5,
    parameter int BASE_INTERVAL = 400,
    parameter int MIN_INTERVAL  = 16,
    parameter int FIRST_DELAY   = 100
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 add_req,
    input  logic [2:0]           add_count,
    input  logic [2:0]           tree_speed,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [NUM_SLOTS-1:0] deploy,
    output logic [NUM_SLOTS-1:0] busy,
    output logic [PEND_W-1:0]    pending,
    output logic                 blocked
);

    localparam int CNT_MAX = (BASE_INTERVAL > FIRST_DELAY) ? BASE_INTERVAL : FIRST_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {IDLE, WAIT, SPAWN, BLOCKED} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       frame_cnt;
    logic [PTR_W-1:0]       ptr;
    logic [CNT_W-1:0]       interval;
    logic [31:0]            shifted;
    logic [PEND_W:0]        pend_sum;
    logic [PEND_W-1:0]      pend_add;
    logic [PEND_W-1:0]      pend_dec;
    logic                   found;
    logic [PTR_W-1:0]       found_idx;
    logic [NUM_SLOTS-1:0]   found_mask;
    logic                   spawn_go;

    always_comb begin
        shifted  = 32'(BASE_INTERVAL) >> tree_speed;
        interval = (shifted < 32'(MIN_INTERVAL)) ? CNT_W'(MIN_INTERVAL) : CNT_W'(shifted);
    end

    always_comb begin
        pend_sum = {1'b0, pending} + (PEND_W+1)'(add_count);
        if (!add_req)
            pend_add = pending;
        else if (pend_sum[PEND_W])
            pend_add = PEND_MAX;
        else
            pend_add = pend_sum[PEND_W-1:0];
        pend_dec = pend_add - PEND_W'(1);
    end

    // Search uses the registered busy map, so a same-cycle slot_done does not free a slot yet.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !busy[(int'(ptr) + i) % NUM_SLOTS]) begin
                found     = 1'b1;
                found_idx = PTR_W'((int'(ptr) + i) % NUM_SLOTS);
            end
        end
        found_mask = NUM_SLOTS'(1) << found_idx;
    end

    assign spawn_go = (state == SPAWN) && enable && !flush;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            frame_cnt <= '0;
            ptr       <= '0;
            deploy    <= '0;
            busy      <= '0;
            pending   <= '0;
            blocked   <= 1'b0;
        end else begin
            busy   <= (busy & ~slot_done) | ((spawn_go && found) ? found_mask : '0);
            deploy <= '0;
            if (flush) begin
                state     <= IDLE;
                frame_cnt <= '0;
                pending   <= '0;
                blocked   <= 1'b0;
            end else begin
                pending <= pend_add;
                if (enable) begin
                    case (state)
                        IDLE: begin
                            if (pend_add != '0) begin
                                state     <= WAIT;
                                frame_cnt <= CNT_W'(FIRST_DELAY);
                            end
                        end
                        WAIT: begin
                            if (startOfFrame) begin
                                if (frame_cnt == CNT_W'(1))
                                    state <= SPAWN;
                                else
                                    frame_cnt <= frame_cnt - CNT_W'(1);
                            end
                        end
                        SPAWN: begin
                            if (found) begin
                                deploy  <= found_mask;
                                ptr     <= (found_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : found_idx + PTR_W'(1);
                                pending <= pend_dec;
                                blocked <= 1'b0;
                                if (pend_dec != '0) begin
                                    state     <= WAIT;
                                    frame_cnt <= interval;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                blocked <= 1'b1;
                                state   <= BLOCKED;
                            end
                        end
                        BLOCKED: begin
                            if (startOfFrame)
                                state <= SPAWN;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spawn_slot_scheduler.sv
// tb/tb_spawn_slot_scheduler.sv - directed self-checking bench for spawn_slot_scheduler
module tb_spawn_slot_scheduler;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        add_req = 1'b0;
    logic [2:0]  add_count = 3'd0;
    logic [2:0]  tree_speed = 3'd0;
    logic [15:0] slot_done = 16'h0;
    logic [15:0] deploy;
    logic [15:0] busy;
    logic [4:0]  pending;
    logic        blocked;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_sof = 0;
    int dep_cnt = 0;
    int dep_lat = 0;
    int mon_err = 0;
    logic [15:0] last_dep = 16'h0;
    logic [15:0] prev_dep = 16'h0;

    spawn_slot_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .flush(flush), .add_req(add_req), .add_count(add_count), .tree_speed(tree_speed),
        .slot_done(slot_done), .deploy(deploy), .busy(busy), .pending(pending), .blocked(blocked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (startOfFrame) last_sof <= cyc;
    end

    // Deploy must be one-hot and never held for two consecutive clocks.
    always @(negedge clk) begin
        prev_dep <= deploy;
        mon_err  <= mon_err + ((!$onehot0(deploy) || (prev_dep != 0 && deploy != 0)) ? 1 : 0);
        if (deploy != 0) begin
            dep_cnt  <= dep_cnt + 1;
            last_dep <= deploy;
            dep_lat  <= cyc - last_sof;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic frame_x(input logic a, input logic [2:0] c, input logic [15:0] sd, input logic fl);
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) begin
            startOfFrame = 1'b0;
            add_req = a; add_count = c; slot_done = sd; flush = fl;
        end
        @(negedge clk) begin
            add_req = 1'b0; add_count = 3'd0; slot_done = 16'h0; flush = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic frames(input int k);
        for (int i = 0; i < k; i++) frame_x(1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic pulse(input logic a, input logic [2:0] c, input logic [15:0] sd, input logic fl);
        @(negedge clk) begin
            add_req = a; add_count = c; slot_done = sd; flush = fl;
        end
        @(negedge clk) begin
            add_req = 1'b0; add_count = 3'd0; slot_done = 16'h0; flush = 1'b0;
        end
    endtask

    task automatic frames_to_deploy(input int max, output int n);
        int d0;
        d0 = dep_cnt;
        n = 0;
        while (n < max && dep_cnt == d0) begin
            frames(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int d0;
        repeat (3) @(negedge clk);
        check("rst_deploy", deploy, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_blocked", blocked, 0);
        resetN = 1'b1;
        enable = 1'b1;

        // 1: two spawns at speed 2 (interval 100)
        tree_speed = 3'd2;
        pulse(1'b1, 3'd2, 16'h0, 1'b0);
        check("t1_pend2", pending, 2);
        frames_to_deploy(150, n);
        check("t1_first_n", n, 100);
        check("t1_first_slot", last_dep, 16'h0001);
        check("t1_latency", dep_lat, 2);
        check("t1_pend1", pending, 1);
        frames_to_deploy(150, n);
        check("t1_second_n", n, 100);
        check("t1_second_slot", last_dep, 16'h0002);
        check("t1_pend0", pending, 0);
        check("t1_busy", busy, 16'h0003);
        d0 = dep_cnt;
        frames(3);
        check("t1_idle_quiet", dep_cnt, d0);

        // 3: interval clamp at speed 7, full 400 at speed 0
        tree_speed = 3'd7;
        pulse(1'b1, 3'd3, 16'h0, 1'b0);
        frames_to_deploy(150, n);
        check("t3_first_n", n, 100);
        check("t3_first_slot", last_dep, 16'h0004);
        tree_speed = 3'd0;
        frames_to_deploy(40, n);
        check("t3_clamp16", n, 16);
        check("t3_slot3", last_dep, 16'h0008);
        frames_to_deploy(450, n);
        check("t3_reload400", n, 400);
        check("t3_slot4", last_dep, 16'h0010);

        // 4: saturation and add coincident with spawn
        repeat (4) pulse(1'b1, 3'd7, 16'h0, 1'b0);
        pulse(1'b1, 3'd2, 16'h0, 1'b0);
        check("t4_pend30", pending, 30);
        pulse(1'b1, 3'd3, 16'h0, 1'b0);
        check("t4_sat31", pending, 31);
        d0 = dep_cnt;
        frames(99);
        check("t4_no_early", dep_cnt, d0);
        frame_x(1'b1, 3'd1, 16'h0, 1'b0);
        check("t4_spawned", dep_cnt, d0 + 1);
        check("t4_slot5", last_dep, 16'h0020);
        check("t4_pend_sat_dec", pending, 30);
        pulse(1'b0, 3'd0, 16'h0, 1'b1);
        check("t4_flush_pend", pending, 0);
        check("t4_flush_busy", busy, 16'h003F);

        // 2: fill all slots, then a blocked spawn released by slot_done[5]
        pulse(1'b0, 3'd0, 16'hFFFF, 1'b0);
        check("t2_released", busy, 16'h0000);
        tree_speed = 3'd7;
        pulse(1'b1, 3'd7, 16'h0, 1'b0);
        pulse(1'b1, 3'd7, 16'h0, 1'b0);
        pulse(1'b1, 3'd4, 16'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            frames_to_deploy(120, n);
            check("t2_fill_n", n, (k == 0) ? 100 : 16);
            check("t2_fill_slot", last_dep, 16'h1 << ((6 + k) % 16));
        end
        check("t2_full", busy, 16'hFFFF);
        check("t2_pend2", pending, 2);
        d0 = dep_cnt;
        frames(16);
        check("t2_blocked", blocked, 1);
        frames(5);
        check("t2_still_blocked", blocked, 1);
        check("t2_no_deploy", dep_cnt, d0);
        frame_x(1'b0, 3'd0, 16'h0020, 1'b0);
        check("t2_same_cycle_done", dep_cnt, d0);
        check("t2_busy_freed", busy, 16'hFFDF);
        frames_to_deploy(3, n);
        check("t2_retry_n", n, 1);
        check("t2_retry_slot", last_dep, 16'h0020);
        check("t2_unblocked", blocked, 0);
        pulse(1'b0, 3'd0, 16'h0050, 1'b0);
        frames_to_deploy(20, n);
        check("t2_ptr6_n", n, 16);
        check("t2_ptr6_slot", last_dep, 16'h0040);
        check("t2_pend0", pending, 0);

        // 5: enable low freezes countdown; flush discards coincident add
        tree_speed = 3'd0;
        pulse(1'b1, 3'd1, 16'h0, 1'b0);
        d0 = dep_cnt;
        frames(90);
        enable = 1'b0;
        frames(20);
        check("t5_frozen", dep_cnt, d0);
        enable = 1'b1;
        frames_to_deploy(15, n);
        check("t5_resume_n", n, 10);
        check("t5_slot4", last_dep, 16'h0010);
        pulse(1'b0, 3'd0, 16'h000F, 1'b0);
        pulse(1'b1, 3'd2, 16'h0, 1'b0);
        frames(5);
        pulse(1'b1, 3'd3, 16'h0, 1'b1);
        check("t5_flush_pend", pending, 0);
        check("t5_flush_blocked", blocked, 0);
        check("t5_flush_busy", busy, 16'hFFF0);
        d0 = dep_cnt;
        frames(101);
        check("t5_flush_quiet", dep_cnt, d0);

        // 6: reset asserted during the SPAWN cycle
        pulse(1'b0, 3'd0, 16'hFF00, 1'b0);
        check("t6_busy_pre", busy, 16'h00F0);
        pulse(1'b1, 3'd1, 16'h0, 1'b0);
        frames(99);
        d0 = dep_cnt;
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) begin
            startOfFrame = 1'b0;
            resetN = 1'b0;
        end
        #1;
        check("t6_deploy", deploy, 0);
        check("t6_busy", busy, 0);
        check("t6_pending", pending, 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        frames(3);
        check("t6_no_pulse", dep_cnt, d0);

        check("monitor", mon_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
